bids22_cmd_sequencer: RTL

//  Upstream command stage for the BIDS22 bid controller. Buffers host operation words {op,data} in a FIFO.

---
 rtl/bids22_cmd_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bids22_cmd_sequencer.sv
// Command sequencer for the BIDS22 bid controller: buffers {op,data} words in a FIFO,
// issues them as one-cycle C_op/C_data pulses once the controller is ready, tracks C_start and errors.
module bids22_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int DATA_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [DATA_W-1:0]      cmd_data,
  output logic [3:0]             C_op,
  output logic [DATA_W-1:0]      C_data,
  output logic                   C_start,
  input  logic                   ready,
  input  logic [2:0]             err,
  input  logic                   roundOver,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   seq_busy,
  output logic                   seq_err_valid,
  output logic [2:0]             seq_err_code,
  output logic [3:0]             seq_err_op,
  output logic                   timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_BID_CHARGE   = 4'h8;
  localparam logic [3:0] OP_ROUND_ACTIVE = 4'h9;
  localparam logic [3:0] OP_ROUND_OVER   = 4'hA;

  typedef enum logic [1:0] {IDLE, WAIT_RDY, ISSUE, CHECK} state_t;

  state_t              state;
  logic [TW-1:0]       timer;
  logic [DATA_W+3:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [3:0]          head_op, iss_op;
  logic [DATA_W-1:0]   head_data;
  logic                push, issue_pop, drop, deq;

  assign {head_op, head_data} = mem[rd_ptr];

  // Full blocks a push even when the head is popped in the same cycle.
  assign cmd_ready = (fifo_count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready && !flush;
  assign issue_pop = (state == WAIT_RDY) && ready && !flush;
  assign drop      = (state == WAIT_RDY) && !ready && (timer == TW'(TIMEOUT)) && !flush;
  assign deq       = issue_pop || drop;
  assign seq_busy  = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push)      mem[wr_ptr] <= {cmd_op, cmd_data};
    if (issue_pop) iss_op      <= head_op;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (deq)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, deq})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      timer         <= '0;
      C_op          <= '0;
      C_data        <= '0;
      C_start       <= 1'b0;
      seq_err_valid <= 1'b0;
      seq_err_code  <= '0;
      seq_err_op    <= '0;
      timeout       <= 1'b0;
    end else begin
      C_op          <= '0;
      C_data        <= '0;
      seq_err_valid <= 1'b0;
      timeout       <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        timer   <= '0;
        C_start <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fifo_count != '0) begin
              state <= WAIT_RDY;
              timer <= '0;
            end
          end
          WAIT_RDY: begin
            // The pulse is loaded on the pop edge so it is visible throughout ISSUE.
            if (ready) begin
              state <= ISSUE;
              if (head_op <= OP_BID_CHARGE) begin
                C_op   <= head_op;
                C_data <= head_data;
              end
            end else if (timer == TW'(TIMEOUT)) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ISSUE: begin
            state <= IDLE;
            if (iss_op <= OP_BID_CHARGE) begin
              state <= CHECK;
            end else if (iss_op == OP_ROUND_ACTIVE) begin
              C_start <= 1'b1;
            end else if (iss_op == OP_ROUND_OVER) begin
              C_start <= 1'b0;
            end else begin
              seq_err_valid <= 1'b1;
              seq_err_code  <= 3'b111;
              seq_err_op    <= iss_op;
            end
          end
          CHECK: begin
            state <= IDLE;
            if (err != 3'b000) begin
              seq_err_valid <= 1'b1;
              seq_err_code  <= err;
              seq_err_op    <= iss_op;
            end
          end
          default: state <= IDLE;
        endcase
        if (roundOver) C_start <= 1'b0;
      end
    end
  end

endmodule
